// File: rtl/if_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_stage_if
// Brief    : Decode handshake, branch redirect and instruction-SRAM signals
//            between the fetch stage (master) and its environment (slave).
// Revision : 1.0
// ============================================================================
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage with pre-IF address generation, branch
//            redirect/squash; IF_INST_BUF_EN adds a stall instruction buffer.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  wire        clk,
  input  wire        reset,
  if_stage_if.master fs_if
);

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_to_fs_valid;
  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_fetch;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic [31:0] w_fs_inst;

  logic        fs_valid_q;
  logic        fs_valid_d;
  logic [31:0] fs_pc_q;
  logic [31:0] fs_pc_d;

  logic        inst_buf_valid;
  logic [31:0] inst_buf;

  // A redirect seen during reset must not disturb the reset fetch address.
  assign w_br_taken    = fs_if.br_bus[32] & ~reset;
  assign w_br_target   = fs_if.br_bus[31:0];

  assign w_to_fs_valid = ~reset;
  assign w_seq_pc      = fs_pc_q + 32'd4;
  assign w_nextpc      = w_br_taken ? w_br_target : w_seq_pc;

  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = ~fs_valid_q | (w_fs_ready_go & fs_if.ds_allowin) | w_br_taken;
  assign w_fetch       = w_to_fs_valid & w_fs_allowin;

  always_comb begin
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    if (w_fetch) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = w_nextpc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q <= 1'b0;
      fs_pc_q    <= RESET_PC - 32'd4;
    end else begin
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        inst_buf_valid_q;
  logic        inst_buf_valid_d;
  logic [31:0] inst_buf_q;
  logic [31:0] inst_buf_d;

  // Capture rdata on the first stall cycle, before the SRAM output may drift.
  always_comb begin
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    if (w_br_taken || w_fetch) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !fs_if.ds_allowin && !inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = fs_if.inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
    end else begin
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

  assign inst_buf_valid = inst_buf_valid_q;
  assign inst_buf       = inst_buf_q;
`else
  assign inst_buf_valid = 1'b0;
  assign inst_buf       = 32'h0;
`endif

  assign w_fs_inst = inst_buf_valid ? inst_buf : fs_if.inst_sram_rdata;

  assign fs_if.fs_to_ds_valid  = fs_valid_q & w_fs_ready_go & ~w_br_taken;
  assign fs_if.fs_to_ds_bus    = {fs_pc_q, w_fs_inst};

  assign fs_if.inst_sram_en    = w_fetch;
  assign fs_if.inst_sram_we    = 4'h0;
  assign fs_if.inst_sram_addr  = w_nextpc;
  assign fs_if.inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage against a fetch-sequence model.
// Revision : 1.0
// ============================================================================
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef IF_INST_BUF_EN
  localparam bit CORRUPT_IDLE = 1'b1;
`else
  localparam bit CORRUPT_IDLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus_if ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fs_if (bus_if)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] salt;

  // Model state: is an instruction in IF, and at which pc.
  bit          m_valid;
  logic [31:0] m_pc;
  // Expected outputs for the cycle currently being driven.
  logic        e_valid;
  logic        e_en;
  logic [31:0] e_addr;
  logic [63:0] e_bus;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c000000) return 32'h02800421;
    return (a * 32'h9e3779b1) ^ salt;
  endfunction

  // SRAM: one-cycle read latency; optionally scribbles on rdata while idle.
  always @(posedge clk) begin
    if (bus_if.inst_sram_en)
      bus_if.inst_sram_rdata <= mem_word(bus_if.inst_sram_addr);
    else if (CORRUPT_IDLE)
      bus_if.inst_sram_rdata <= 32'hdeadbeef;
  end

  task automatic drive(input logic rst, input logic allow, input logic bt, input logic [31:0] tgt);
    logic br_eff;
    @(negedge clk);
    reset             = rst;
    bus_if.ds_allowin = allow;
    bus_if.br_bus     = {bt, tgt};
    br_eff  = bt & ~rst;
    e_valid = m_valid & ~br_eff;
    e_en    = ~rst & (~m_valid | allow | br_eff);
    e_addr  = br_eff ? tgt : m_pc + 32'd4;
    e_bus   = {m_pc, mem_word(m_pc)};
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
    end else if (e_en) begin
      m_valid = 1'b1;
      m_pc    = e_addr;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      advance();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, (i == 2), 32'h1c000500);
      checks++;
      if (bus_if.inst_sram_en !== 1'b0 || bus_if.fs_to_ds_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: en=%b valid=%b required en=0 valid=0", bus_if.inst_sram_en, bus_if.fs_to_ds_valid);
      end
      if (i > 0) begin
        checks++;
        if (bus_if.inst_sram_addr !== RESET_PC) begin
          errors++;
          $display("FAIL reset_addr: got %h required %h", bus_if.inst_sram_addr, RESET_PC);
        end
      end
      checks++;
      if (bus_if.inst_sram_we !== 4'h0 || bus_if.inst_sram_wdata !== 32'h0) begin
        errors++;
        $display("FAIL sram_write_consts: we=%h wdata=%h required 0/0", bus_if.inst_sram_we, bus_if.inst_sram_wdata);
      end
      advance();
    end
  endtask

  task automatic test_first_fetch();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== 32'h1c000000 || bus_if.fs_to_ds_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: en=%b addr=%h valid=%b required 1/1c000000/0", bus_if.inst_sram_en, bus_if.inst_sram_addr, bus_if.fs_to_ds_valid);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== 64'h1c000000_02800421) begin
      errors++;
      $display("FAIL first_inst: valid=%b bus=%h required 1/1c00000002800421", bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_bus[63:32] !== 32'h1c000004) begin
      errors++;
      $display("FAIL second_pc: got %h required 1c000004", bus_if.fs_to_ds_bus[63:32]);
    end
    advance();
  endtask

  task automatic test_stream();
    do_reset();
    run(1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.inst_sram_en !== 1'b1 ||
          bus_if.fs_to_ds_bus[63:32] !== RESET_PC + 32'(4 * i) || bus_if.fs_to_ds_bus !== e_bus) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b en=%b bus=%h required 1/1/%h", i,
                 bus_if.fs_to_ds_valid, bus_if.inst_sram_en, bus_if.fs_to_ds_bus, e_bus);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    do_reset();
    run(3);
    held = {32'h1c000008, mem_word(32'h1c000008)};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== held ||
          bus_if.inst_sram_en !== 1'b0 || bus_if.inst_sram_addr !== 32'h1c00000c) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b bus=%h en=%b addr=%h required 1/%h/0/1c00000c", i,
                 bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus, bus_if.inst_sram_en, bus_if.inst_sram_addr, held);
      end
      advance();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_bus !== held || bus_if.inst_sram_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: bus=%h en=%b required %h/1", bus_if.fs_to_ds_bus, bus_if.inst_sram_en, held);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_bus !== {32'h1c00000c, mem_word(32'h1c00000c)}) begin
      errors++;
      $display("FAIL stall_resume: bus=%h required pc 1c00000c", bus_if.fs_to_ds_bus);
    end
    advance();
  endtask

  task automatic test_branch();
    do_reset();
    run(5);
    drive(1'b0, 1'b1, 1'b1, 32'h1c000100);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_addr !== 32'h1c000100 || bus_if.inst_sram_en !== 1'b1) begin
      errors++;
      $display("FAIL branch_squash: valid=%b addr=%h en=%b required 0/1c000100/1",
               bus_if.fs_to_ds_valid, bus_if.inst_sram_addr, bus_if.inst_sram_en);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== {32'h1c000100, mem_word(32'h1c000100)}) begin
      errors++;
      $display("FAIL branch_target: valid=%b bus=%h required 1/%h", bus_if.fs_to_ds_valid,
               bus_if.fs_to_ds_bus, {32'h1c000100, mem_word(32'h1c000100)});
    end
    advance();
  endtask

  task automatic test_stall_branch();
    do_reset();
    run(2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h1c000200);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== 32'h1c000200) begin
      errors++;
      $display("FAIL stall_branch: valid=%b en=%b addr=%h required 0/1/1c000200",
               bus_if.fs_to_ds_valid, bus_if.inst_sram_en, bus_if.inst_sram_addr);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== {32'h1c000200, mem_word(32'h1c000200)}) begin
      errors++;
      $display("FAIL stall_branch_target: valid=%b bus=%h required 1/%h", bus_if.fs_to_ds_valid,
               bus_if.fs_to_ds_bus, {32'h1c000200, mem_word(32'h1c000200)});
    end
    advance();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    run(2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%b en=%b addr=%h required 0/1/%h",
               bus_if.fs_to_ds_valid, bus_if.inst_sram_en, bus_if.inst_sram_addr, RESET_PC);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.fs_to_ds_bus !== 64'h1c000000_02800421) begin
      errors++;
      $display("FAIL reset_restart: valid=%b bus=%h required 1/1c00000002800421",
               bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus);
    end
    advance();
  endtask

  task automatic test_random();
    logic        rst, allow, bt;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      allow = ($urandom_range(0, 3) != 0);
      bt    = ($urandom_range(0, 5) == 0);
      tgt   = 32'h1c000000 | ($urandom & 32'h0000fffc);
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(0, 3));
      drive(rst, allow, bt, tgt);
      checks++;
      if (bus_if.fs_to_ds_valid !== e_valid || bus_if.inst_sram_en !== e_en || bus_if.inst_sram_addr !== e_addr) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: valid=%b en=%b addr=%h required %b/%b/%h", i,
                 bus_if.fs_to_ds_valid, bus_if.inst_sram_en, bus_if.inst_sram_addr, e_valid, e_en, e_addr);
      end
      if (e_valid) begin
        checks++;
        if (bus_if.fs_to_ds_bus !== e_bus) begin
          errors++;
          $display("FAIL random_bus[%0d]: got %h required %h", i, bus_if.fs_to_ds_bus, e_bus);
        end
      end
      advance();
    end
  endtask

  initial begin
    salt              = $urandom;
    m_valid           = 1'b0;
    m_pc              = RESET_PC - 32'd4;
    bus_if.ds_allowin = 1'b1;
    bus_if.br_bus     = 33'h0;
    test_reset();
    test_first_fetch();
    test_stream();
    test_stall();
    test_branch();
    test_stall_branch();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the pipelined LoongArch CPU core.
- Owns the PC and a pre-IF address-generation step, and drives the synchronous instruction SRAM.
- Passes {pc, inst} to the decode stage over a valid/allowin handshake.
- Redirects on taken branches/jumps resolved in decode and squashes the wrong-path instruction.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  decode stage can accept an instruction this cycle.
- br_bus  in  33  {br_taken, br_target[31:0]}; br_taken is a single-cycle pulse from decode.
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
- fs_to_ds_bus  out  64  {fs_pc[31:0], fs_inst[31:0]}.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_we  out  4  byte write enables; constant 4'h0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 32'h0.
- inst_sram_rdata  in  32  read data; 1-cycle latency after en.

## Operation
- Pre-IF signals:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4 (mod 2^32).
  - nextpc = br_taken ? br_target : seq_pc.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
  - fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
- Fetch request:
  - inst_sram_en = to_fs_valid & fs_allowin.
  - inst_sram_addr = nextpc.
- Register update: when to_fs_valid & fs_allowin, fs_valid <= 1 and fs_pc <= nextpc. When fs_allowin is 0, fs_valid, fs_pc and the address hold.
- br_taken:
  - Decode asserts it only in the cycle the branch leaves decode.
  - The instruction currently in IF is wrong-path and is squashed (fs_to_ds_valid = 0 that cycle).
  - br_target is fetched in the same cycle.
  - br_taken is ignored while reset = 1.
- br_target alignment is decode's responsibility. IF does not check it; bits [1:0] pass through to the SRAM address unchanged.
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata (see Configuration).

## Timing
- Reset values:
  - fs_valid = 0, fs_to_ds_valid = 0.
  - fs_pc = RESET_PC - 4, so nextpc = RESET_PC.
  - inst_sram_en = 0.
  - inst_buf_valid = 0.
- First cycle with reset = 0 (cycle 0): inst_sram_en = 1, addr = RESET_PC.
- Cycle 1: fs_to_ds_valid = 1, fs_pc = RESET_PC, fs_inst = mem[RESET_PC].
- Throughput: one instruction per cycle while ds_allowin = 1. Latency is 1 cycle from address presentation to instruction valid.
- Stall (fs_valid & ~ds_allowin): inst_sram_en = 0 and fs_pc holds. fs_to_ds_valid stays 1 with an unchanged bus until ds_allowin = 1.
- br_taken during a cycle with fs_valid = 0: redirect only, nothing is squashed.
- br_taken in the same cycle as reset: reset wins.
- Reset asserted mid-stall: all state returns to reset values on the next edge; any buffered instruction is discarded.

## Configuration
- IF_INST_BUF_EN defined:
  - In the first stall cycle (fs_valid & ~ds_allowin & ~inst_buf_valid & ~br_taken), inst_sram_rdata is captured into inst_buf and inst_buf_valid is set to 1.
  - Cleared on reset, br_taken, or any cycle where to_fs_valid & fs_allowin.
  - fs_inst comes from inst_buf while inst_buf_valid = 1.
  - Stalls are correct even if SRAM rdata changes while en = 0.
- IF_INST_BUF_EN undefined:
  - No buffer; inst_buf_valid is tied to 0 and fs_inst = inst_sram_rdata.
  - The SRAM must hold its output while en = 0.

## Test plan
- Reset release, ds_allowin = 1, mem[1c000000] = 32'h02800421: cycle 0 addr = 1c000000 with en = 1; cycle 1 valid = 1, bus = {1c000000, 02800421}; cycle 2 pc = 1c000004.
- Stream 8 cycles with ds_allowin = 1: PCs 1c000000..1c00001c are consecutive, one per cycle, and en is high every cycle.
- Stall 3 cycles at pc = 1c000008, with the SRAM model driving 32'hdeadbeef on rdata while en = 0:
  - With IF_INST_BUF_EN: bus holds the original instruction throughout.
  - Without it: the test is run only with a holding SRAM model.
  - Either way: en = 0 and the address is unchanged during the stall; on resume the next pc is 1c00000c.
- br_bus = {1, 1c000100} while fs_pc = 1c000010: fs_to_ds_valid = 0 that cycle, addr = 1c000100; next cycle bus = {1c000100, mem[1c000100]}.
- Stall, then ds_allowin = 1 together with br_taken (target 1c000200): buffered instruction discarded, no valid output that cycle; next valid pc = 1c000200.
- Reset pulsed during a stall with inst_buf_valid = 1: valid = 0 the next cycle; after release, fetch restarts at 1c000000.
